// File: rtl/fb_fetch_if.sv
// fb_fetch_if: single-port framebuffer SRAM bus between the fetch client and the sram block.
// The master modport drives the SRAM request; the slave modport returns read data.
interface fb_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic [ADDR_WIDTH-1:0] o_sram_addr;
  logic                  o_sram_write;
  logic [DATA_WIDTH-1:0] o_sram_data;
  logic [DATA_WIDTH-1:0] i_sram_data;

  modport master (
    output o_sram_addr,
    output o_sram_write,
    output o_sram_data,
    input  i_sram_data
  );

  modport slave (
    input  o_sram_addr,
    input  o_sram_write,
    input  o_sram_data,
    output i_sram_data
  );

endinterface

// File: rtl/fb_fetch.sv
// fb_fetch: streams framebuffer pixels from SRAM into a prefetch FIFO and interleaves host writes.
// Define FB_FETCH_UNDERRUN_EN to add the sticky o_underrun flag.
module fb_fetch #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FB_DEPTH   = 19200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_frame_start,
  input  logic                  i_pix_req,
  output logic [DATA_WIDTH-1:0] o_pix,
  output logic                  o_pix_valid,
  input  logic                  i_wr_req,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ack,
`ifdef FB_FETCH_UNDERRUN_EN
  output logic                  o_underrun,
`endif
  fb_fetch_if.master            sram
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_DEPTH - 1);

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_e;

  logic [ADDR_WIDTH-1:0] rd_addr_q,    rd_addr_d;
  logic [PTR_W-1:0]      rd_ptr_q,     rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q,     wr_ptr_d;
  logic [CNT_W-1:0]      count_q,      count_d;
  logic [1:0]            inflight_q,   inflight_d;
  logic                  valid_q,      valid_d;
  logic [ADDR_WIDTH-1:0] sram_addr_q,  sram_addr_d;
  logic                  sram_write_q, sram_write_d;
  logic [DATA_WIDTH-1:0] sram_data_q,  sram_data_d;
  logic                  wr_ack_q,     wr_ack_d;
  logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];

  op_e              op_c;
  logic [OCC_W-1:0] occ_c;
  logic             urgent_c;
  logic             space_c;
  logic             wr_ok_c;
  logic             push_c;
  logic             pop_c;

  // Occupancy counts reads already issued so the FIFO can never overflow.
  always_comb begin
    occ_c    = OCC_W'(count_q) + OCC_W'(inflight_q[0]) + OCC_W'(inflight_q[1]);
    urgent_c = (occ_c < OCC_W'(2));
    space_c  = (occ_c < OCC_W'(FIFO_DEPTH));
    wr_ok_c  = i_wr_req & ~wr_ack_q;
    push_c   = inflight_q[1] & ~i_frame_start;
    pop_c    = i_pix_req & valid_q & ~i_frame_start;
  end

  // Arbiter: a starving display beats the host; the host beats opportunistic prefetch.
  always_comb begin
    op_c = OP_IDLE;
    if (urgent_c && space_c && !i_frame_start) begin
      op_c = OP_READ;
    end else if (wr_ok_c) begin
      op_c = OP_WRITE;
    end else if (space_c && !i_frame_start) begin
      op_c = OP_READ;
    end
  end

  always_comb begin
    rd_addr_d    = rd_addr_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    inflight_d   = {inflight_q[0], (op_c == OP_READ)};
    sram_addr_d  = sram_addr_q;
    sram_write_d = 1'b0;
    sram_data_d  = sram_data_q;
    wr_ack_d     = 1'b0;

    unique case (op_c)
      OP_READ: begin
        sram_addr_d = rd_addr_q;
        rd_addr_d   = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + ADDR_WIDTH'(1);
      end
      OP_WRITE: begin
        sram_addr_d  = i_wr_addr;
        sram_data_d  = i_wr_data;
        sram_write_d = 1'b1;
        wr_ack_d     = 1'b1;
      end
      default: ;
    endcase

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

    // Frame restart drops everything queued or in flight; a host write may still proceed.
    if (i_frame_start) begin
      rd_addr_d  = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      inflight_d = '0;
    end

    valid_d = (count_d != '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_addr_q    <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      inflight_q   <= '0;
      valid_q      <= 1'b0;
      sram_addr_q  <= '0;
      sram_write_q <= 1'b0;
      sram_data_q  <= '0;
      wr_ack_q     <= 1'b0;
    end else begin
      rd_addr_q    <= rd_addr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      valid_q      <= valid_d;
      sram_addr_q  <= sram_addr_d;
      sram_write_q <= sram_write_d;
      sram_data_q  <= sram_data_d;
      wr_ack_q     <= wr_ack_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (push_c) begin
      fifo_q[wr_ptr_q] <= sram.i_sram_data;
    end
  end

`ifdef FB_FETCH_UNDERRUN_EN
  logic underrun_q, underrun_d;

  // Sticky flag; a starved pop in the restart cycle still sets it.
  always_comb begin
    underrun_d = underrun_q;
    if (i_frame_start) begin
      underrun_d = 1'b0;
    end
    if (i_pix_req && !valid_q) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
    end
  end

  assign o_underrun = underrun_q;
`endif

  assign o_pix            = valid_q ? fifo_q[rd_ptr_q] : '0;
  assign o_pix_valid      = valid_q;
  assign o_wr_ack         = wr_ack_q;
  assign sram.o_sram_addr  = sram_addr_q;
  assign sram.o_sram_write = sram_write_q;
  assign sram.o_sram_data  = sram_data_q;

endmodule
